// File: rtl/shape_processor_scheduler_if.sv
// Requester, shape-processor and response signals of shape_processor_scheduler.
// The master modport is the scheduler's view, the slave modport the environment's view.
interface shape_processor_scheduler_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 req0_valid;
  logic                 req1_valid;
  logic [31:0]          req0_data;
  logic [31:0]          req1_data;
  logic                 req0_ready;
  logic                 req1_ready;
  logic                 write;
  logic [31:0]          write_data;
  logic                 read;
  logic [31:0]          read_data;
  logic                 error;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_error;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    input  req0_valid, req1_valid, req0_data, req1_data, read_data, error, rsp_ready,
    output req0_ready, req1_ready, write, write_data, read, rsp_valid, rsp_id, rsp_data,
           rsp_error, err_count
  );

  modport slave (
    output req0_valid, req1_valid, req0_data, req1_data, read_data, error, rsp_ready,
    input  req0_ready, req1_ready, write, write_data, read, rsp_valid, rsp_id, rsp_data,
           rsp_error, err_count
  );
endinterface

// File: rtl/shape_processor_scheduler.sv
// Round-robin scheduler of two CTRL writers onto a shape processor: write, reject check,
// optional readback (macro SHAPE_PROCESSOR_SCHEDULER_READBACK_EN), then one response.
module shape_processor_scheduler #(
  parameter int ERR_CNT_W = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  shape_processor_scheduler_if.master bus
);
`ifdef SHAPE_PROCESSOR_SCHEDULER_READBACK_EN
  typedef enum logic [2:0] {IDLE = 3'd0, WRITE = 3'd1, CHECK = 3'd2, READ = 3'd3, RESP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, WRITE = 3'd1, CHECK = 3'd2, RESP = 3'd4} state_t;
`endif

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1'b1);

  state_t               state;
  state_t               state_next;
  logic                 last_id;
  logic                 grant_any;
  logic                 grant_id;
  logic [ERR_CNT_W-1:0] err_count;

`ifndef SHAPE_PROCESSOR_SCHEDULER_READBACK_EN
  logic unused_read_data;
  assign unused_read_data = ^bus.read_data;
`endif

  // Next-state logic and round-robin grant; a tie goes to the requester not granted last.
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant_any = 1'b1;
          grant_id  = ~last_id;
        end else if (bus.req0_valid || bus.req1_valid) begin
          grant_any = 1'b1;
          grant_id  = bus.req1_valid;
        end else begin
          grant_any = 1'b0;
        end
        state_next = grant_any ? WRITE : IDLE;
      end
      WRITE: state_next = CHECK;
`ifdef SHAPE_PROCESSOR_SCHEDULER_READBACK_EN
      CHECK: state_next = READ;
      READ:  state_next = RESP;
`else
      CHECK: state_next = RESP;
`endif
      RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accept strobe must coincide with the grant decision, so it cannot be registered.
  assign bus.req0_ready = rst_n && grant_any && !grant_id;
  assign bus.req1_ready = rst_n && grant_any && grant_id;
  assign bus.err_count  = err_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered strobes and response payload, aligned with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.write      <= 1'b0;
      bus.read       <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_error  <= 1'b0;
      bus.write_data <= 32'h0000_0000;
      bus.rsp_data   <= 32'h0000_0000;
      err_count      <= {ERR_CNT_W{1'b0}};
      last_id        <= 1'b1;
    end else begin
      bus.write     <= (state_next == WRITE);
      bus.rsp_valid <= (state_next == RESP);
`ifdef SHAPE_PROCESSOR_SCHEDULER_READBACK_EN
      bus.read      <= (state_next == READ);
      if (state == READ) begin
        bus.rsp_data <= bus.read_data;
      end
`else
      bus.read      <= 1'b0;
      bus.rsp_data  <= 32'h0000_0000;
`endif
      if (grant_any) begin
        bus.write_data <= grant_id ? bus.req1_data : bus.req0_data;
        bus.rsp_id     <= grant_id;
        last_id        <= grant_id;
      end
      if (state == CHECK) begin
        bus.rsp_error <= bus.error;
        if (bus.error && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_shape_processor_scheduler.sv
// Scoreboard bench for shape_processor_scheduler: directed commands push expected responses,
// a forked monitor pops and compares on every write strobe and response handshake.
`timescale 1ns/1ps
module tb_shape_processor_scheduler;
`ifdef SHAPE_PROCESSOR_SCHEDULER_READBACK_EN
  localparam bit RB  = 1'b1;
  localparam int LAT = 4;
`else
  localparam bit RB  = 1'b0;
  localparam int LAT = 3;
`endif

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    logic [1:0]  cnt;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  shape_processor_scheduler_if #(.ERR_CNT_W(2)) sif();
  shape_processor_scheduler #(.ERR_CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

  always #5 clk = ~clk;

  rsp_t        exp_q[$];
  logic [31:0] wr_q[$];
  int          checks    = 0;
  int          fails     = 0;
  int          cyc       = 0;
  int          grant_cyc = 0;
  int          n_writes  = 0;
  int          n_reads   = 0;
  bit          err_inject = 1'b0;
  bit          err_noise  = 1'b0;
  bit          stall_chk  = 1'b0;
  bit          quiet_chk  = 1'b0;
  logic [31:0] rd_val     = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor plus shape-processor model: error is raised only in the cycle after write unless noise is on.
  task automatic monitor();
    bit          prev_write;
    bit          prev_rv;
    rsp_t        e;
    logic [31:0] w;
    prev_write = 1'b0;
    prev_rv    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      sif.error  = prev_write ? err_inject : err_noise;
      prev_write = sif.write;
      if (!rst_n) begin
        check("reset_data", sif.write_data | sif.rsp_data, 32'h0);
        check("reset_ctrl", {23'h0, sif.write, sif.read, sif.req0_ready, sif.req1_ready,
                             sif.rsp_valid, sif.rsp_id, sif.rsp_error, sif.err_count}, 32'h0);
      end else begin
        if (sif.req0_ready || sif.req1_ready) begin
          check("single_ready", 32'(sif.req0_ready & sif.req1_ready), 32'h0);
          grant_cyc = cyc;
        end
        if (sif.write) begin
          n_writes++;
          check("write_expected", 32'(wr_q.size() > 0), 32'h1);
          if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check("write_data", sif.write_data, w);
          end
        end
        if (sif.read) n_reads++;
        if (sif.rsp_valid && !prev_rv) check("latency", 32'(cyc - grant_cyc), 32'(LAT));
        if (stall_chk && exp_q.size() > 0) begin
          check("stall_ctrl", {26'h0, sif.rsp_valid, sif.req0_ready, sif.req1_ready, sif.write,
                               sif.rsp_id, sif.rsp_error},
                {26'h0, 1'b1, 3'b000, exp_q[0].id, exp_q[0].err});
          check("stall_data", sif.rsp_data, exp_q[0].data);
        end
        if (quiet_chk) check("quiet_after_reset", {29'h0, sif.write, sif.read, sif.rsp_valid}, 32'h0);
        if (sif.rsp_valid && sif.rsp_ready) begin
          check("rsp_expected", 32'(exp_q.size() > 0), 32'h1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(sif.rsp_id), 32'(e.id));
            check("rsp_data", sif.rsp_data, e.data);
            check("rsp_error", 32'(sif.rsp_error), 32'(e.err));
            check("err_count", 32'(sif.err_count), 32'(e.cnt));
          end
        end
      end
      prev_rv = rst_n && sif.rsp_valid;
    end
  endtask

  task automatic issue(input logic id, input logic [31:0] d, input logic e, input logic [1:0] c,
                       input bit want_rsp);
    rsp_t r;
    r.id   = id;
    r.data = RB ? rd_val : 32'h0;
    r.err  = e;
    r.cnt  = c;
    if (want_rsp) exp_q.push_back(r);
    wr_q.push_back(d);
    if (id) begin
      sif.req1_data  = d;
      sif.req1_valid = 1'b1;
    end else begin
      sif.req0_data  = d;
      sif.req0_valid = 1'b1;
    end
  endtask

  task automatic wait_grant(input logic id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (id ? sif.req1_ready : sif.req0_ready) got = 1'b1;
    end
    check(id ? "grant_req1" : "grant_req0", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    if (id) sif.req1_valid = 1'b0;
    else    sif.req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    sif.req0_valid = 1'b0;
    sif.req1_valid = 1'b0;
    sif.req0_data  = 32'h0;
    sif.req1_data  = 32'h0;
    sif.read_data  = 32'h0;
    sif.error      = 1'b0;
    sif.rsp_ready  = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tie straight out of reset: requester 0 first, then requester 1.
    rd_val = 32'hA5A5_0001; sif.read_data = rd_val;
    issue(1'b0, 32'h0000_0102, 1'b0, 2'd0, 1'b1);
    issue(1'b1, 32'h0000_0201, 1'b0, 2'd0, 1'b1);
    wait_grant(1'b0);
    wait_grant(1'b1);
    drain();

    // Lone requester 1 wins although it was granted last.
    rd_val = 32'h0000_0011; sif.read_data = rd_val;
    issue(1'b1, 32'h0000_0042, 1'b0, 2'd0, 1'b1);
    wait_grant(1'b1);
    drain();

    // Five rejected writes saturate a 2-bit counter.
    err_inject = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      issue(1'b0, 32'h0000_1000 + 32'(k), 1'b1, (k > 3) ? 2'd3 : 2'(k), 1'b1);
      wait_grant(1'b0);
      drain();
    end
    err_inject = 1'b0;

    // error held high outside the check cycle must be ignored.
    err_noise = 1'b1;
    rd_val = 32'h0BAD_F00D; sif.read_data = rd_val;
    issue(1'b1, 32'h0000_2000, 1'b0, 2'd3, 1'b1);
    wait_grant(1'b1);
    drain();
    err_noise = 1'b0;

    // Response back-pressure with another request pending.
    sif.rsp_ready = 1'b0;
    rd_val = 32'h0000_3333; sif.read_data = rd_val;
    issue(1'b0, 32'h0000_0300, 1'b0, 2'd3, 1'b1);
    wait_grant(1'b0);
    issue(1'b1, 32'h0000_0400, 1'b0, 2'd3, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sif.rsp_valid) seen = 1'b1;
    end
    check("rsp_valid_stall", 32'(seen), 32'h1);
    @(posedge clk);
    #1 stall_chk = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    stall_chk     = 1'b0;
    sif.rsp_ready = 1'b1;
    wait_grant(1'b1);
    drain();

    // Reset during CHECK abandons the command; afterwards requester 0 wins the tie again.
    rd_val = 32'h0000_5555; sif.read_data = rd_val;
    issue(1'b1, 32'h0000_0500, 1'b0, 2'd3, 1'b0);
    wait_grant(1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet_chk = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 quiet_chk = 1'b0;
    rd_val = 32'h0000_6666; sif.read_data = rd_val;
    issue(1'b0, 32'h0000_0600, 1'b0, 2'd0, 1'b1);
    issue(1'b1, 32'h0000_0700, 1'b0, 2'd0, 1'b1);
    wait_grant(1'b0);
    wait_grant(1'b1);
    drain();

    check("write_count", 32'(n_writes), 32'd14);
    check("read_count", 32'(n_reads), RB ? 32'd13 : 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/shape_processor_scheduler.md
SHAPE_PROCESSOR_SCHEDULER -- requirements
Module: shape_processor_scheduler

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating rejected-write counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester i has a CTRL write pending.
REQ-005 SHALL have ports req0_data/req1_data  input  32  CTRL write data of requester i.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  one-cycle accept strobe to requester i.
REQ-007 SHALL have port write  output  1  write strobe to the shape processor.
REQ-008 SHALL have port write_data  output  32  data driven to the shape processor with write.
REQ-009 SHALL have port read  output  1  read strobe to the shape processor.
REQ-010 SHALL have port read_data  input  32  shape processor CTRL readback, valid in the same cycle as read.
REQ-011 SHALL have port error  input  1  shape processor reject flag, valid the cycle after write.
REQ-012 SHALL have ports rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-013 SHALL have ports rsp_id  output  1, rsp_data  output  32, rsp_error  output  1  response payload: granted requester, readback, reject flag.
REQ-014 SHALL have port err_count  output  ERR_CNT_W  count of rejected writes.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, CHECK, READ, RESP, with one command in flight at a time.
REQ-016 IDLE: if any reqi_valid, grant by round-robin (requester not granted last wins a tie), pulse reqi_ready for that cycle, latch reqi_data and id, go to WRITE; else stay.
REQ-017 With exactly one requester valid, that requester SHALL be granted regardless of last grant.
REQ-018 WRITE: write=1 for exactly one cycle, write_data=latched data; go to CHECK.
REQ-019 CHECK: sample error into rsp_error; if 1, increment err_count saturating at 2^ERR_CNT_W-1; go to READ.
REQ-020 READ: read=1 for exactly one cycle, capture read_data into rsp_data; go to RESP.
REQ-021 RESP: rsp_valid=1 with stable rsp_id/rsp_data/rsp_error until rsp_valid&&rsp_ready; then go to IDLE, with no new grant in that cycle.
REQ-022 write, read, reqi_ready SHALL be 0 in every state not listed above; never both reqi_ready high in the same cycle.
REQ-023 Minimum command latency SHALL be 4 cycles from grant to rsp_valid; the next grant SHALL come no earlier than the cycle after the response handshake.
REQ-024 reqi_valid deasserting after grant SHALL NOT affect the in-flight command.
REQ-025 error outside the CHECK cycle SHALL be ignored.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE; write, read, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_error=0; write_data, rsp_data=0; err_count=0; last grant=requester 1, so requester 0 wins the first tie.
REQ-027 Reset mid-command SHALL abandon the command with no response and no further write/read.

Configuration
REQ-028 Macro SHAPE_PROCESSOR_SCHEDULER_READBACK_EN defined: READ state as specified.
REQ-029 Macro undefined: no READ state; CHECK goes directly to RESP; read tied to 0; rsp_data=0; minimum latency 3 cycles.

Verification
REQ-030 Both valid from reset, req0_data=32'h0000_0102, req1_data=32'h0000_0201 -> req0 granted first, write_data=32'h0000_0102, rsp_id=0; then req1 granted, rsp_id=1.
REQ-031 Only req1 valid, error=0, read_data=32'h0000_0011 in READ -> rsp_id=1, rsp_data=32'h0000_0011, rsp_error=0, rsp_valid 4 cycles after grant.
REQ-032 error=1 in CHECK, ERR_CNT_W=2, five rejected commands -> rsp_error=1 each time, err_count 1,2,3,3,3.
REQ-033 rsp_ready held 0 for 10 cycles with new requests pending -> rsp_valid and payload stable, no reqi_ready, no write.
REQ-034 rst_n pulsed low during CHECK -> all outputs 0 immediately, no rsp_valid, next request restarts at IDLE with req0 priority.
REQ-035 Macro undefined -> read never 1, rsp_data=0, rsp_valid 3 cycles after grant.
